ppwm_ramp_ctrl: RTL

PPWM_RAMP_CTRL -- requirements
Module: ppwm_ramp_ctrl

---
 rtl/ppwm_ramp_ctrl.sv | 117 +++++++++++
 1 files changed

// File: rtl/ppwm_ramp_ctrl.sv
// ppwm_ramp_ctrl: steps a PWM compare value toward a target once per PWM period, dwells there, then finishes
// Ports:
//   clk, rst           - clock, asynchronous active-high reset
//   target_i/step_i/hold_i - ramp target, per-period increment, dwell periods (sampled on accepted start_i)
//   start_i, abort_i   - begin a ramp (IDLE only) / stop immediately (wins over start_i)
//   period_start_i     - one-cycle pulse at every PWM period boundary
//   cmp_value_o, pwm_set_o - compare value and its one-cycle load strobe to the PWM generator
//   busy_o, done_o     - not IDLE / one-cycle completion pulse
// Macro PPWM_RAMP_BREATHE_EN: after the dwell, ramp down to 0, dwell, ramp back up to target, forever until abort_i.
module ppwm_ramp_ctrl #(
    parameter int WIDTH      = 10,
    parameter int STEP_WIDTH = 4,
    parameter int HOLD_WIDTH = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [WIDTH-1:0]      target_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [HOLD_WIDTH-1:0] hold_i,
    input  logic                  start_i,
    input  logic                  abort_i,
    input  logic                  period_start_i,
    output logic [WIDTH-1:0]      cmp_value_o,
    output logic                  pwm_set_o,
    output logic                  busy_o,
    output logic                  done_o
);
    typedef enum logic [1:0] {IDLE, UP, DOWN, HOLD} state_t;
    state_t state, state_n;
    logic [WIDTH-1:0] cmp_n, tgt, tgt_n, goal, goal_n, up_val, dn_val;
    logic [STEP_WIDTH-1:0] stp, stp_n;
    logic [HOLD_WIDTH-1:0] hld, hld_n, cnt, cnt_n;
    logic [WIDTH:0] up_sum, dn_diff;
    logic set_n, done_n, expire;

    // goal is the end point of the current ramp: the target, or 0 on the breathing down-leg
    assign busy_o  = state != IDLE;
    assign up_sum  = {1'b0, cmp_value_o} + (WIDTH+1)'(stp);
    assign dn_diff = {1'b0, cmp_value_o} - (WIDTH+1)'(stp);
    assign up_val  = up_sum >= {1'b0, goal} ? goal : up_sum[WIDTH-1:0];
    assign dn_val  = (dn_diff[WIDTH] || dn_diff[WIDTH-1:0] <= goal) ? goal : dn_diff[WIDTH-1:0];
    assign expire  = hld == '0 || (period_start_i && {1'b0, cnt} + (HOLD_WIDTH+1)'(1) == {1'b0, hld});

    always_comb begin
        state_n = state;
        cmp_n   = cmp_value_o;
        set_n   = 1'b0;
        done_n  = 1'b0;
        tgt_n   = tgt;
        stp_n   = stp;
        hld_n   = hld;
        cnt_n   = cnt;
        goal_n  = goal;
        if (abort_i) begin
            state_n = IDLE;
        end else begin
            case (state)
                IDLE: if (start_i) begin
                    tgt_n   = target_i;
                    goal_n  = target_i;
                    stp_n   = step_i == '0 ? STEP_WIDTH'(1) : step_i;
                    hld_n   = hold_i;
                    cnt_n   = '0;
                    state_n = target_i > cmp_value_o ? UP : target_i < cmp_value_o ? DOWN : HOLD;
                end
                UP: if (period_start_i) begin
                    cmp_n   = up_val;
                    set_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = up_val == goal ? HOLD : UP;
                end
                DOWN: if (period_start_i) begin
                    cmp_n   = dn_val;
                    set_n   = 1'b1;
                    cnt_n   = '0;
                    state_n = dn_val == goal ? HOLD : DOWN;
                end
                default: if (expire) begin
`ifdef PPWM_RAMP_BREATHE_EN
                    goal_n  = cmp_value_o == tgt ? '0 : tgt;
                    cnt_n   = '0;
                    state_n = goal_n > cmp_value_o ? UP : goal_n < cmp_value_o ? DOWN : HOLD;
`else
                    state_n = IDLE;
                    done_n  = 1'b1;
`endif
                end else if (period_start_i) begin
                    cnt_n = cnt + HOLD_WIDTH'(1);
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            cmp_value_o <= '0;
            pwm_set_o   <= 1'b0;
            done_o      <= 1'b0;
            tgt         <= '0;
            goal        <= '0;
            stp         <= '0;
            hld         <= '0;
            cnt         <= '0;
        end else begin
            state       <= state_n;
            cmp_value_o <= cmp_n;
            pwm_set_o   <= set_n;
            done_o      <= done_n;
            tgt         <= tgt_n;
            goal        <= goal_n;
            stp         <= stp_n;
            hld         <= hld_n;
            cnt         <= cnt_n;
        end
    end
endmodule
